// File: rtl/uart_tx_mmio.sv
// Generic byte FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
// Latency: a pushed entry is visible at the head on the edge after the push.
// Backpressure: push_rdy low when full with no pop; pop_vld low when empty.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  output logic                   push_rdy,
  output logic                   pop_vld,
  output logic [W-1:0]           pop_dat,
  input  logic                   pop_rdy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_pop   = pop_vld && pop_rdy;
  assign push_rdy = (count != FULL_CNT) || do_pop;
  assign do_push  = push_vld && push_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Memory-mapped 8N1 UART transmitter (TXDATA/STATUS/CTRL); `UART_TX_IRQ_EN adds irq_o and CTRL.irq_en.
// Latency: TXDATA write into an empty FIFO with an idle line drives the start bit from the next edge.
// Backpressure: none on the bus; writes to a full FIFO are dropped and set the sticky overflow flag.
module uart_tx_mmio #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [2:0]  size_i,
  output logic [31:0] rdata_o,
  output logic        hit_o,
`ifdef UART_TX_IRQ_EN
  output logic        irq_o,
`endif
  output logic        tx
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int QW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_mmio: CLK_HZ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_mmio: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          cnt_end;

  logic [1:0]    reg_sel;
  logic          wr_en;
  logic          push_vld, push_rdy;
  logic          pop_vld, pop_rdy;
  logic [7:0]    pop_dat;
  logic [QW-1:0] fifo_count;
  logic          fifo_full;
  logic          overflow;
  logic [31:0]   status;
  logic          unused_ok;

  assign hit_o    = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = addr_i[3:2];
  assign wr_en    = we_i && hit_o;
  assign push_vld = wr_en && (reg_sel == 2'd0);
  assign unused_ok = ^{size_i, addr_i[1:0], wdata_i[31:8]};

  uart_tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (wdata_i[7:0]),
    .push_rdy (push_rdy),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .pop_rdy  (pop_rdy),
    .count    (fifo_count)
  );

  assign fifo_full = (fifo_count == QW'(FIFO_DEPTH));
  assign status    = {20'h0, 4'(fifo_count), 4'h0, overflow, !pop_vld, fifo_full, state != S_IDLE};
  assign cnt_end   = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      tx    <= tx_nxt;
    end
  end

  // tx is registered from the next state so the start bit appears on the pop edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    pop_rdy   = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      S_IDLE: begin
        pop_rdy = 1'b1;
        if (pop_vld) begin
          shift_nxt = pop_dat;
          cnt_nxt   = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt_end) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          cnt_nxt = '0;
          if (idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            shift_nxt = shift >> 1;
            idx_nxt   = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_end) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_vld && !push_rdy) begin
      overflow <= 1'b1;
    end else if (wr_en && (reg_sel == 2'd1) && wdata_i[3]) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == 2'd2)) irq_en <= wdata_i[0];
      irq_o <= irq_en && !pop_vld && (state == S_IDLE);
    end
  end
`endif

  always_comb begin
    rdata_o = '0;
    if (re_i && hit_o) begin
      case (reg_sel)
        2'd1:    rdata_o = status;
`ifdef UART_TX_IRQ_EN
        2'd2:    rdata_o = {31'h0, irq_en};
`endif
        default: rdata_o = '0;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data bus, alongside the data RAM. It consumes CPU store traffic (address, write data, write/read enables, size) and drives the UART tx pin.
- Bytes written to TXDATA are queued in a small FIFO and serialised as 8N1 frames at a fixed baud rate.
- The top level routes data_we/data_re to this block when the address falls in its window.
- Read data is ORed or muxed with RAM read data by the top level.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate. DIV = CLK_HZ/BAUD, truncated; DIV must be >= 2, otherwise elaboration error.
- FIFO_DEPTH, 8: TX FIFO entries, power of 2, >= 2.
- BASE_ADDR, 32'h1000_0000: window base; window is BASE_ADDR..BASE_ADDR+0xF, word-aligned registers.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_i  in  32  data bus address.
- wdata_i  in  32  data bus write data.
- we_i  in  1  write enable, sampled on rising clk.
- re_i  in  1  read enable.
- size_i  in  3  access size (byte/half/word); ignored except as noted.
- rdata_o  out  32  read data, combinational.
- hit_o  out  1  combinational: addr_i inside window.
- tx  out  1  UART serial output, registered.

Behaviour:
- Reset (async assert, sync release): tx=1, FIFO empty, overflow flag=0, FSM=IDLE, baud counter=0, bit index=0. rdata_o is combinational and reads per the current register values.
- Register map (offset = addr_i[3:0]; addr_i[1:0] ignored):
  - 0x0 TXDATA, write-only: push wdata_i[7:0] for any size_i. Reads return 0.
  - 0x4 STATUS, read: bit0 busy (FSM != IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bits[11:8] FIFO count (zero-extended/truncated to 4 bits); others 0. Write with wdata_i[3]=1 clears overflow; other bits ignored.
  - 0x8 CTRL, and 0xC: read 0, writes ignored (see Optional Feature).
- rdata_o = selected register when re_i && hit_o, else 32'h0.
- Writes take effect only when we_i && hit_o.
- FIFO push accepted when not full, or when full and a pop occurs the same cycle. Otherwise the byte is dropped and overflow is set on that edge.
- FSM, with baud counter cnt counting 0..DIV-1:
  - IDLE: tx=1. If FIFO non-empty: pop head into shift register, cnt=0, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit is held DIV cycles; then shift right and increment index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
- Latency: push on edge k with FIFO previously empty and FSM idle → pop and START on edge k+1 → tx low from k+1.
- Frame length is exactly 10*DIV cycles from START entry to IDLE re-entry.
- Back-to-back: with the FIFO non-empty at STOP end, the FSM passes through IDLE for exactly 1 cycle (tx=1), then the next START begins. The stop bit is therefore DIV+1 cycles between queued frames.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is held in a separate log2(DEPTH)+1-bit register.
- Reset mid-frame: tx forced to 1 immediately (async). Queued bytes are lost.

Optional Feature:
- Macro UART_TX_IRQ_EN.
- When defined:
  - Adds port irq_o  out  1.
  - CTRL offset 0x8: bit0 irq_en, read/write, reset 0.
  - irq_o registered: 1 when irq_en && FIFO empty && FSM==IDLE; updates one cycle after the condition changes; reset 0.
- When undefined: no irq_o port; 0x8 reads 0, writes ignored.

Test Plan (CLK_HZ=1000000, BAUD=100000, DIV=10, FIFO_DEPTH=8, BASE 0x1000_0000):
1. Write 0x55 to 0x1000_0000 at edge k → tx low for cycles k+1..k+10, then 1,0,1,0,1,0,1,0 each 10 cycles, high stop. STATUS busy=1 during the frame, STATUS=0x0000_0004 after cycle k+101.
2. Write 9 bytes back-to-back while idle → first byte pops at the 2nd write edge, so all 9 accepted, overflow=0. A 10th write while count=8 and FSM busy → dropped, STATUS bit3=1, count=8. Write 0x8 to 0x1000_0004 → bit3 cleared.
3. Queue 0xA5, 0x3C → two frames; exactly 11 high cycles between the first frame's stop start and the second start bit; total 201 cycles.
4. Read 0x1000_0004 with re_i=0 → rdata_o=0. Read 0x2000_0004 with re_i=1 → hit_o=0, rdata_o=0. Write 0xFF to 0x2000_0000 → no FIFO push.
5. Assert rst mid-DATA (tx=0) → tx=1 asynchronously. After release STATUS=0x0000_0004 and tx stays 1.
6. (UART_TX_IRQ_EN) Write 1 to 0x1000_0008 while idle → irq_o=1 next cycle. Push byte → irq_o=0 next edge; returns 1 one cycle after the FSM re-enters IDLE with the FIFO empty.
